cla_pipe_adder: RTL

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined add/subtract unit built from
// carry-lookahead groups. Stage 1 adds the low half and registers the carry
// together with the high-half operands. Stage 2 adds the high half and
// registers the result and its flags. Both stages use a valid/ready handshake.
module cla_pipe_adder #(
  parameter int WIDTH = 24,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Ci,
  input  logic             Sub,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf,
  output logic             Zero
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / GROUP;

  // One lookahead group. Every carry is an independent sum of products of
  // the group's generate/propagate terms and cin, so no carry inside the
  // group depends on another carry of the same group.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             cin);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic [GROUP-1:0] s;
    logic             term;
    p    = a ^ b;
    g    = a & b;
    c    = {(GROUP+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
      term = cin;
      for (int k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = c[i+1] | term;
    end
    s = p ^ c[GROUP-1:0];
    return {c[GROUP], s};
  endfunction

  // Half-width adder: lookahead groups chained by their group carries.
  function automatic logic [HALF:0] add_half(input logic [HALF-1:0] a,
                                             input logic [HALF-1:0] b,
                                             input logic            cin);
    logic [HALF-1:0] s;
    logic            carry;
    logic [GROUP:0]  r;
    s     = {HALF{1'b0}};
    carry = cin;
    for (int g = 0; g < NGRP; g++) begin
      r = cla_group(a[g*GROUP +: GROUP], b[g*GROUP +: GROUP], carry);
      s[g*GROUP +: GROUP] = r[GROUP-1:0];
      carry = r[GROUP];
    end
    return {carry, s};
  endfunction

  // Pipeline state
  logic             live_q,       live_d;
  logic             s1_valid_q,   s1_valid_d;
  logic [HALF-1:0]  s1_sum_lo_q,  s1_sum_lo_d;
  logic             s1_carry_q,   s1_carry_d;
  logic [HALF-1:0]  s1_x_hi_q,    s1_x_hi_d;
  logic [HALF-1:0]  s1_b_hi_q,    s1_b_hi_d;
  logic             s2_valid_q,   s2_valid_d;
  logic [WIDTH-1:0] sum_q,        sum_d;
  logic             co_q,         co_d;
  logic             ovf_q,        ovf_d;
  logic             zero_q,       zero_d;

  // Combinational helpers
  logic             s2_ready_s;
  logic             move_s;
  logic             in_fire_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [HALF:0]    lo_s;
  logic [HALF:0]    hi_s;
  logic [WIDTH-1:0] res_sum_s;

  // Stage 2 can take new data when it is empty or its result leaves now;
  // live_q keeps the input closed until the first edge after reset.
  assign s2_ready_s = ~s2_valid_q | Out_ready;
  assign move_s     = s1_valid_q & s2_ready_s;
  assign In_ready   = live_q & (~s1_valid_q | s2_ready_s);
  assign in_fire_s  = In_valid & In_ready;

  // Subtract is X + ~Y + ~Ci, which equals X - Y - Ci.
  assign b_eff_s   = Sub ? ~Y : Y;
  assign cin_eff_s = Sub ? ~Ci : Ci;
  assign lo_s      = add_half(X[HALF-1:0], b_eff_s[HALF-1:0], cin_eff_s);
  assign hi_s      = add_half(s1_x_hi_q, s1_b_hi_q, s1_carry_q);
  assign res_sum_s = {hi_s[HALF-1:0], s1_sum_lo_q};

  assign Out_valid = s2_valid_q;
  assign Sum       = sum_q;
  assign Co        = co_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

  // Next-state for stage 1: capture on input transfer, empty when it drains.
  always_comb begin
    live_d      = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_sum_lo_d = s1_sum_lo_q;
    s1_carry_d  = s1_carry_q;
    s1_x_hi_d   = s1_x_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    if (in_fire_s) begin
      s1_valid_d  = 1'b1;
      s1_sum_lo_d = lo_s[HALF-1:0];
      s1_carry_d  = lo_s[HALF];
      s1_x_hi_d   = X[WIDTH-1:HALF];
      s1_b_hi_d   = b_eff_s[WIDTH-1:HALF];
    end else if (move_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Next-state for stage 2: finish the high half when stage 1 moves down,
  // otherwise hold so the result stays stable under backpressure.
  always_comb begin
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    co_d       = co_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = res_sum_s;
        co_d   = hi_s[HALF];
        ovf_d  = (s1_x_hi_q[HALF-1] == s1_b_hi_q[HALF-1]) &
                 (res_sum_s[WIDTH-1] != s1_x_hi_q[HALF-1]);
        zero_d = (res_sum_s == {WIDTH{1'b0}});
      end else begin
        sum_d = sum_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with asynchronous clear; reset discards all in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sum_lo_q <= {HALF{1'b0}};
      s1_carry_q  <= 1'b0;
      s1_x_hi_q   <= {HALF{1'b0}};
      s1_b_hi_q   <= {HALF{1'b0}};
      s2_valid_q  <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      live_q      <= live_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_lo_q <= s1_sum_lo_d;
      s1_carry_q  <= s1_carry_d;
      s1_x_hi_q   <= s1_x_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s2_valid_q  <= s2_valid_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

endmodule
